riscv_dcache: RTL and testbench

// - Responder end of the pipeline's data-memory interface: the direct-mapped, write-back, write-allocate data cache.
// - Accepts the word-aligned request driven from the DX stage (dcache_addr/re/we/din).
// - Returns the load word to the MW stage one cycle later on dcache_dout.
// - Raises mem_stall while it services misses over a single-beat line interface to backing memory.

---
 rtl/riscv_dcache_pkg.sv | 32 +++
 rtl/riscv_dcache_if.sv | 35 +++
 rtl/dcache_line_store.sv | 42 ++++
 rtl/riscv_dcache.sv | 163 ++++++++++++++++
 tb/tb_riscv_dcache.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// geometry, derived field widths, FSM encoding and line-select helper.
package riscv_dcache_pkg;

    localparam int unsigned LINES          = 64;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned LINE_W         = 32 * WORDS_PER_LINE;
    localparam int unsigned WORD_W         = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W          = $clog2(LINES);
    localparam int unsigned OFF_W          = WORD_W + 2;
    localparam int unsigned TAG_W          = 32 - OFF_W - IDX_W;
    localparam int unsigned LSEL_W         = $clog2(LINE_W);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_RESPOND
    } state_t;

    // Bit offset of a 32-bit word inside a line.
    function automatic logic [LSEL_W-1:0] word_lsb(input word_t w);
        return {w, 5'd0};
    endfunction

endpackage

// File: rtl/riscv_dcache_if.sv
// Pipeline-side request/response signals plus the single-beat line
// interface to backing memory.
interface riscv_dcache_if;
    import riscv_dcache_pkg::*;

    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        mem_stall;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    line_t       mem_req_data;
    logic        mem_resp_valid;
    line_t       mem_resp_data;

    modport slave (
        input  dcache_addr, dcache_re, dcache_we, dcache_din,
        output dcache_dout, mem_stall,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output dcache_addr, dcache_re, dcache_we, dcache_din,
        input  dcache_dout, mem_stall,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/dcache_line_store.sv
// Cache data array: combinational line read, byte-masked word write and
// full-line refill write (refill has priority).
module dcache_line_store
    import riscv_dcache_pkg::*;
(
    input  logic        clk,
    input  idx_t        rd_idx,
    output line_t       rd_line,
    input  logic        wr_en,
    input  idx_t        wr_idx,
    input  word_t       wr_word,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    input  logic        fill_en,
    input  idx_t        fill_idx,
    input  line_t       fill_line
);

    line_t data [LINES];
    line_t merged;

    assign rd_line = data[rd_idx];

    // Merge the masked store bytes into the current line contents.
    always_comb begin
        merged = data[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
                merged[{wr_word, 2'(b), 3'd0} +: 8] = wr_data[{2'(b), 3'd0} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data[fill_idx] <= fill_line;
        end else if (wr_en) begin
            data[wr_idx] <= merged;
        end
    end

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped, write-back, write-allocate data cache answering the DX/MW
// pipeline with one-cycle hit latency and stalling while a miss is serviced.
module riscv_dcache
    import riscv_dcache_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    riscv_dcache_if.slave  bus
);

    state_t             state;
    state_t             state_next;
    logic               pending;
    logic [29:0]        req_addr;
    logic [3:0]         req_we;
    logic [31:0]        req_din;
    logic [31:0]        dout_q;
    tag_t               tags [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    tag_t               req_tag;
    idx_t               req_idx;
    word_t              req_word;
    line_t              rd_line;
    logic [31:0]        word;
    logic               hit;
    logic               victim_dirty;
    logic               stall;
    logic               respond;
    logic               accept;
    logic               fill_en;
    logic               wr_en;
    logic               unused_addr_lsb;

    // Byte offset within the word is a don't-care for word-aligned traffic.
    assign unused_addr_lsb = ^bus.dcache_addr[1:0];

    assign req_word = req_addr[WORD_W-1:0];
    assign req_idx  = req_addr[WORD_W+IDX_W-1:WORD_W];
    assign req_tag  = req_addr[29:WORD_W+IDX_W];

    assign hit          = valid[req_idx] && (tags[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] && dirty[req_idx];
    assign word         = rd_line[word_lsb(req_word) +: 32];

    assign stall   = pending && (((state == ST_IDLE) && !hit) ||
                                 (state == ST_WRITEBACK) ||
                                 (state == ST_REFILL_REQ) ||
                                 (state == ST_REFILL_WAIT));
    assign respond = pending && (((state == ST_IDLE) && hit) || (state == ST_RESPOND));
    assign accept  = !stall && (bus.dcache_re || (|bus.dcache_we));
    assign fill_en = !rst && (state == ST_REFILL_WAIT) && bus.mem_resp_valid;
    assign wr_en   = !rst && respond && (|req_we);

    assign bus.mem_stall   = stall;
    assign bus.dcache_dout = respond ? word : dout_q;

    dcache_line_store u_store (
        .clk       (clk),
        .rd_idx    (req_idx),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_word   (req_word),
        .wr_mask   (req_we),
        .wr_data   (req_din),
        .fill_en   (fill_en),
        .fill_idx  (req_idx),
        .fill_line (bus.mem_resp_data)
    );

    // Request capture, response hold register and line status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            req_addr <= '0;
            req_we   <= '0;
            req_din  <= '0;
            dout_q   <= '0;
            valid    <= '0;
            dirty    <= '0;
        end else begin
            if (!stall) begin
                pending <= accept;
            end
            if (accept) begin
                req_addr <= bus.dcache_addr[31:2];
                req_we   <= bus.dcache_we;
                req_din  <= bus.dcache_din;
            end
            if (respond) begin
                dout_q <= word;
            end
            if (fill_en) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end else if (wr_en) begin
                dirty[req_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[req_idx] <= req_tag;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pending && !hit) begin
                    state_next = victim_dirty ? ST_WRITEBACK : ST_REFILL_REQ;
                end
            end
            ST_WRITEBACK: begin
                if (bus.mem_req_ready) state_next = ST_REFILL_REQ;
            end
            ST_REFILL_REQ: begin
                if (bus.mem_req_ready) state_next = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (bus.mem_resp_valid) state_next = ST_RESPOND;
            end
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: memory line request, held stable by the state and request regs.
    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_data  = '0;
        case (state)
            ST_WRITEBACK: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_rw    = 1'b1;
                bus.mem_req_addr  = {tags[req_idx], req_idx, {OFF_W{1'b0}}};
                bus.mem_req_data  = rd_line;
            end
            ST_REFILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_dcache.sv
// Bench for riscv_dcache: scoreboard of expected load words from a flat memory
// reference, a behavioural backing memory, and directed scenarios.
module tb_riscv_dcache;
    import riscv_dcache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_dcache_if bus ();

    riscv_dcache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        line_t       data;
    } mreq_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];
    logic        due = 1'b0;
    mreq_t       req_log [$];
    line_t       bmem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ready_delay = 0;
    bit          drop_resp = 1'b0;
    bit          inject = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic line_t bmem_line(input logic [31:0] la);
        line_t l;
        if (bmem.exists(la)) return bmem[la];
        for (int i = 0; i < int'(WORDS_PER_LINE); i++) l[32*i +: 32] = pat(la + 32'(4*i));
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        line_t l;
        if (ref_mem.exists(a)) return ref_mem[a];
        l = bmem_line(a & ~32'(LINE_W/8 - 1));
        return l[32*int'(a[OFF_W-1:2]) +: 32];
    endfunction

    function automatic line_t ref_line(input logic [31:0] la);
        line_t l;
        for (int i = 0; i < int'(WORDS_PER_LINE); i++) l[32*i +: 32] = ref_word(la + 32'(4*i));
        return l;
    endfunction

    // Backing memory: accepts line requests after ready_delay cycles, answers reads two cycles later.
    initial begin
        int    wait_cnt;
        int    resp_cnt;
        line_t resp_line;
        wait_cnt = 0;
        resp_cnt = 0;
        resp_line = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (rst) begin
                wait_cnt = 0;
                resp_cnt = 0;
            end
            if (inject) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = {WORDS_PER_LINE{32'hDEAD_DEAD}};
                inject = 1'b0;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = resp_line;
                end
            end
            if (bus.mem_req_valid === 1'b1 && !rst) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt++;
                end else begin
                    mreq_t e;
                    wait_cnt = 0;
                    bus.mem_req_ready = 1'b1;
                    e.rw   = bus.mem_req_rw;
                    e.addr = bus.mem_req_addr;
                    e.data = bus.mem_req_data;
                    req_log.push_back(e);
                    if (bus.mem_req_rw) begin
                        bmem[bus.mem_req_addr] = bus.mem_req_data;
                    end else if (!drop_resp) begin
                        resp_cnt  = 2;
                        resp_line = bmem_line(bus.mem_req_addr);
                    end
                end
            end
        end
    end

    // Response monitor: compare dcache_dout in every response cycle against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            due = 1'b0;
        end else begin
            if (due && bus.mem_stall === 1'b0) begin
                logic [31:0] exp;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: response %h with no expected word", bus.dcache_dout);
                end else begin
                    exp = sb.pop_front();
                    if (bus.dcache_dout !== exp) begin
                        n_fail++;
                        $display("FAIL load_data: got %h expected %h", bus.dcache_dout, exp);
                    end
                end
                due = 1'b0;
            end
            if (bus.mem_stall === 1'b0 && (bus.dcache_re || (|bus.dcache_we))) due = 1'b1;
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        bus.dcache_re = 1'b0;
        bus.dcache_we = 4'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                          output int waits);
        logic [31:0] aw;
        logic [31:0] old;
        logic [31:0] nw;
        aw  = {a[31:2], 2'b00};
        old = ref_word(aw);
        sb.push_back(old);
        if (we != 4'b0) begin
            nw = old;
            for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = din[8*b +: 8];
            ref_mem[aw] = nw;
        end
        @(posedge clk); #1;
        bus.dcache_addr = a;
        bus.dcache_re   = (we == 4'b0);
        bus.dcache_we   = we;
        bus.dcache_din  = din;
        waits = 0;
        while (bus.mem_stall === 1'b1 && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: addr %h still stalled after %0d cycles", a, waits);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        idle();
        while ((sb.size() != 0 || due) && n < 300) begin
            idle();
            n++;
        end
        if (n >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL response_timeout: %0d responses outstanding", sb.size());
        end
    endtask

    task automatic test_reset();
        bus.dcache_addr = '0;
        bus.dcache_re   = 1'b0;
        bus.dcache_we   = 4'b0;
        bus.dcache_din  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++;
        if (bus.mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.mem_stall); end
        n_tests++;
        if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.mem_req_valid); end
        n_tests++;
        if (bus.dcache_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.dcache_dout); end
    endtask

    task automatic test_cold_load();
        int    w;
        mreq_t e;
        req_log.delete();
        do_req(32'h0000_1004, 4'b0, 32'h0, w);
        idle();
        n_tests++;
        if (bus.mem_stall !== 1'b1) begin n_fail++; $display("FAIL cold_miss_stall: got %b expected 1", bus.mem_stall); end
        wait_done();
        n_tests++;
        if (req_log.size() != 1) begin
            n_fail++; $display("FAIL cold_req_count: got %0d expected 1", req_log.size());
        end else begin
            e = req_log.pop_front();
            n_tests++;
            if (e.rw !== 1'b0 || e.addr !== 32'h0000_1000) begin
                n_fail++; $display("FAIL cold_refill_req: got rw=%b addr=%h expected rw=0 addr=00001000", e.rw, e.addr);
            end
        end
        idle();
        n_tests++;
        if (bus.dcache_dout !== 32'h1004_EFFB) begin n_fail++; $display("FAIL dout_hold: got %h expected 1004effb", bus.dcache_dout); end
    endtask

    task automatic test_back_to_back();
        int w1;
        int w2;
        req_log.delete();
        do_req(32'h0000_1004, 4'b0011, 32'h0000_BEEF, w1);
        do_req(32'h0000_1004, 4'b0000, 32'h0, w2);
        n_tests++;
        if (w1 != 0 || w2 != 0) begin n_fail++; $display("FAIL b2b_accept: got waits %0d/%0d expected 0/0", w1, w2); end
        idle();
        n_tests++;
        if (bus.mem_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_hit_stall: got %b expected 0", bus.mem_stall); end
        n_tests++;
        if (bus.dcache_dout !== 32'h1004_BEEF) begin n_fail++; $display("FAIL b2b_load_new: got %h expected 1004beef", bus.dcache_dout); end
        wait_done();
        n_tests++;
        if (req_log.size() != 0) begin n_fail++; $display("FAIL b2b_mem_traffic: got %0d requests expected 0", req_log.size()); end
    endtask

    task automatic test_dirty_conflict();
        int    w;
        line_t exp;
        mreq_t e0;
        mreq_t e1;
        req_log.delete();
        exp = ref_line(32'h0000_1000);
        do_req(32'h0000_1404, 4'b0, 32'h0, w);
        wait_done();
        n_tests++;
        if (req_log.size() != 2) begin
            n_fail++; $display("FAIL conflict_req_count: got %0d expected 2", req_log.size());
        end else begin
            e0 = req_log.pop_front();
            e1 = req_log.pop_front();
            n_tests++;
            if (e0.rw !== 1'b1 || e0.addr !== 32'h0000_1000) begin
                n_fail++; $display("FAIL conflict_wb_req: got rw=%b addr=%h expected rw=1 addr=00001000", e0.rw, e0.addr);
            end
            n_tests++;
            if (e0.data !== exp) begin n_fail++; $display("FAIL conflict_wb_data: got %h expected %h", e0.data, exp); end
            n_tests++;
            if (e1.rw !== 1'b0 || e1.addr !== 32'h0000_1400) begin
                n_fail++; $display("FAIL conflict_refill_req: got rw=%b addr=%h expected rw=0 addr=00001400", e1.rw, e1.addr);
            end
        end
    endtask

    task automatic test_ready_hold();
        int    w;
        line_t exp;
        mreq_t e;
        req_log.delete();
        do_req(32'h0000_1404, 4'b1111, 32'hCAFE_F00D, w);
        wait_done();
        exp = ref_line(32'h0000_1400);
        ready_delay = 5;
        do_req(32'h0000_1804, 4'b0, 32'h0, w);
        idle();
        for (int i = 0; i < 5; i++) begin
            idle();
            n_tests++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_rw !== 1'b1 || bus.mem_req_addr !== 32'h0000_1400 ||
                bus.mem_req_data !== exp || bus.mem_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v=%b rw=%b addr=%h stall=%b data=%h expected v=1 rw=1 addr=00001400 stall=1 data=%h",
                         i, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr, bus.mem_stall, bus.mem_req_data, exp);
            end
        end
        wait_done();
        ready_delay = 0;
        n_tests++;
        if (req_log.size() != 2) begin
            n_fail++; $display("FAIL hold_req_count: got %0d expected 2", req_log.size());
        end else begin
            e = req_log.pop_front();
            void'(req_log.pop_front());
            n_tests++;
            if (e.rw !== 1'b1 || e.data !== exp) begin n_fail++; $display("FAIL hold_wb_data: got rw=%b data=%h expected rw=1 data=%h", e.rw, e.data, exp); end
        end
    endtask

    task automatic test_reset_mid_miss();
        int    w;
        int    n;
        mreq_t e;
        req_log.delete();
        drop_resp = 1'b1;
        do_req(32'h0000_1C04, 4'b0, 32'h0, w);
        n = 0;
        while (req_log.size() == 0 && n < 50) begin idle(); n++; end
        n_tests++;
        if (n >= 50) begin n_fail++; $display("FAIL rst_refill_seen: got no refill request expected one"); end
        idle();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_tests++;
        if (bus.mem_req_valid !== 1'b0 || bus.mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_miss: got v=%b stall=%b expected v=0 stall=0", bus.mem_req_valid, bus.mem_stall);
        end
        inject = 1'b1;
        repeat (3) idle();
        n_tests++;
        if (bus.mem_req_valid !== 1'b0 || bus.mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_late_resp: got v=%b stall=%b expected v=0 stall=0", bus.mem_req_valid, bus.mem_stall);
        end
        drop_resp = 1'b0;
        ref_mem.delete();
        req_log.delete();
        do_req(32'h0000_1004, 4'b0, 32'h0, w);
        idle();
        n_tests++;
        if (bus.mem_stall !== 1'b1) begin n_fail++; $display("FAIL rst_reload_miss: got stall %b expected 1", bus.mem_stall); end
        wait_done();
        n_tests++;
        if (req_log.size() != 1) begin
            n_fail++; $display("FAIL rst_reload_reqs: got %0d expected 1", req_log.size());
        end else begin
            e = req_log.pop_front();
            n_tests++;
            if (e.rw !== 1'b0 || e.addr !== 32'h0000_1000) begin
                n_fail++; $display("FAIL rst_reload_req: got rw=%b addr=%h expected rw=0 addr=00001000", e.rw, e.addr);
            end
        end
    endtask

    task automatic test_spurious();
        int w;
        int n;
        inject = 1'b1;
        repeat (3) idle();
        do_req(32'h0000_1004, 4'b0, 32'h0, w);
        idle();
        n_tests++;
        if (w != 0 || bus.mem_stall !== 1'b0) begin n_fail++; $display("FAIL spurious_hit: got waits=%0d stall=%b expected 0/0", w, bus.mem_stall); end
        wait_done();
        req_log.delete();
        do_req(32'h0000_2004, 4'b0, 32'h0, w);
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_stall === 1'b1) begin
                bus.dcache_addr = 32'h0000_2000 | 32'($urandom_range(0, 3) << 2);
                bus.dcache_we   = 4'hF;
                bus.dcache_re   = 1'($urandom_range(0, 1));
                bus.dcache_din  = $urandom;
            end else begin
                bus.dcache_re = 1'b0;
                bus.dcache_we = 4'b0;
                break;
            end
        end
        wait_done();
        do_req(32'h0000_2008, 4'b0, 32'h0, w);
        do_req(32'h0000_200C, 4'b0, 32'h0, w);
        do_req(32'h0000_1008, 4'b0, 32'h0, w);
        wait_done();
        n_tests++;
        if (req_log.size() != 2 || req_log[0].rw !== 1'b0 || req_log[1].rw !== 1'b0) begin
            n_fail++; $display("FAIL stall_inputs_ignored: got %0d requests (expected 2 refills, no write-back)", req_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_back_to_back();
        test_dirty_conflict();
        test_ready_hold();
        test_reset_mid_miss();
        test_spurious();
        repeat (2) idle();
        n_tests++;
        if (sb.size() != 0 || due) begin n_fail++; $display("FAIL sb_leftover: got %0d outstanding expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
